// File: rtl/alu_writeback_regfile.sv
// Register file, status-flag register and branch-condition evaluator that
// sits on both sides of the single-cycle ALU: two combinational read ports
// feed the operands, and the result/flags are captured on the next edge.
module alu_writeback_regfile #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_BITS-1:0] rd_addr1,
    output logic [WIDTH-1:0]     rd_data1,
    input  logic [ADDR_BITS-1:0] rd_addr2,
    output logic [WIDTH-1:0]     rd_data2,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [2:0]           alu_op,
    input  logic                 set_flags,
    input  logic                 carry_in,
    input  logic                 overflow_in,
    input  logic                 negative_in,
    input  logic                 zero_in,
    input  logic [3:0]           cond,
    output logic [3:0]           flags,
    output logic                 branch_taken
);

    localparam int NUM_REGS = 2 ** ADDR_BITS;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic             flag_c, flag_v, flag_n, flag_z;
    logic             arith_op;
    logic             bypass1, bypass2;

    // ADD and SUB own the carry/overflow flags; every other opcode preserves them.
    assign arith_op = (alu_op == 3'b000) || (alu_op == 3'b001);

    // Register array: cleared on reset, otherwise one write per cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: this array is cleared explicitly because reset must leave every
            // register at zero; that forces flops rather than a RAM macro, which is
            // acceptable at 8 entries.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            // NOTE: non-blocking so every reader in this edge sees the pre-edge value.
            regs[wr_addr] <= wr_data;
        end
    end

    // Write-through bypass so an operand written this cycle is readable now;
    // disabled during reset because the write will be discarded.
    assign bypass1  = reset_n && wr_en && (rd_addr1 == wr_addr);
    assign bypass2  = reset_n && wr_en && (rd_addr2 == wr_addr);
    assign rd_data1 = bypass1 ? wr_data : regs[rd_addr1];
    assign rd_data2 = bypass2 ? wr_data : regs[rd_addr2];

    // Status register: arithmetic loads all four flags, logical/move loads N and Z.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
        end else if (set_flags) begin
            if (arith_op) begin
                flag_c <= carry_in;
                flag_v <= overflow_in;
                flag_n <= negative_in;
            end else begin
                flag_n <= wr_data[WIDTH-1];
            end
            flag_z <= zero_in;
        end
    end

    assign flags = {flag_c, flag_v, flag_n, flag_z};

    // Branch condition resolved against the latched flags only (no in-flight bypass).
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        branch_taken = 1'b0;
        case (cond_e'(cond))
            COND_EQ: branch_taken = flag_z;
            COND_NE: branch_taken = !flag_z;
            COND_CS: branch_taken = flag_c;
            COND_CC: branch_taken = !flag_c;
            COND_MI: branch_taken = flag_n;
            COND_PL: branch_taken = !flag_n;
            COND_VS: branch_taken = flag_v;
            COND_VC: branch_taken = !flag_v;
            COND_HI: branch_taken = flag_c && !flag_z;
            COND_LS: branch_taken = !flag_c || flag_z;
            COND_GE: branch_taken = (flag_n == flag_v);
            COND_LT: branch_taken = (flag_n != flag_v);
            COND_GT: branch_taken = !flag_z && (flag_n == flag_v);
            COND_LE: branch_taken = flag_z || (flag_n != flag_v);
            COND_AL: branch_taken = 1'b1;
            COND_NV: branch_taken = 1'b0;
            default: branch_taken = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_writeback_regfile.sv
// Self-checking bench for alu_writeback_regfile: directed scenarios with
// literal expectations, then randomized traffic compared every cycle against
// a behavioural model of the register file, flags and condition table.
module tb_alu_writeback_regfile;

    localparam int WIDTH     = 16;
    localparam int ADDR_BITS = 3;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [ADDR_BITS-1:0] rd_addr1, rd_addr2, wr_addr;
    logic [WIDTH-1:0]     rd_data1, rd_data2, wr_data;
    logic                 wr_en, set_flags;
    logic [2:0]           alu_op;
    logic                 carry_in, overflow_in, negative_in, zero_in;
    logic [3:0]           cond, flags;
    logic                 branch_taken;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model state
    logic [WIDTH-1:0] m_regs [8];
    logic [3:0]       m_flags;   // {C, V, N, Z}

    alu_writeback_regfile #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_op(alu_op), .set_flags(set_flags),
        .carry_in(carry_in), .overflow_in(overflow_in),
        .negative_in(negative_in), .zero_in(zero_in),
        .cond(cond), .flags(flags), .branch_taken(branch_taken)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Condition table evaluated on a {C,V,N,Z} nibble.
    function automatic logic exp_branch(input logic [3:0] c, input logic [3:0] f);
        logic fc, fv, fn, fz;
        fc = f[3]; fv = f[2]; fn = f[1]; fz = f[0];
        case (c)
            4'd0:  return fz;
            4'd1:  return !fz;
            4'd2:  return fc;
            4'd3:  return !fc;
            4'd4:  return fn;
            4'd5:  return !fn;
            4'd6:  return fv;
            4'd7:  return !fv;
            4'd8:  return fc && !fz;
            4'd9:  return !fc || fz;
            4'd10: return fn == fv;
            4'd11: return fn != fv;
            4'd12: return !fz && (fn == fv);
            4'd13: return fz || (fn != fv);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] exp_read(input logic [ADDR_BITS-1:0] a);
        if (reset_n && wr_en && a == wr_addr) return wr_data;
        return m_regs[a];
    endfunction

    // Model update on each rising edge
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) m_regs[i] <= '0;
            m_flags <= 4'b0000;
        end else begin
            if (wr_en) m_regs[wr_addr] <= wr_data;
            if (set_flags) begin
                if (alu_op <= 3'd1)
                    m_flags <= {carry_in, overflow_in, negative_in, zero_in};
                else
                    m_flags <= {m_flags[3:2], wr_data[WIDTH-1], zero_in};
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("rd_data1", 32'(rd_data1), 32'(exp_read(rd_addr1)));
            check("rd_data2", 32'(rd_data2), 32'(exp_read(rd_addr2)));
            check("flags", 32'(flags), 32'(m_flags));
            check("branch_taken", 32'(branch_taken), 32'(exp_branch(cond, m_flags)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        set_flags = 1'b0; alu_op = 3'd0;
        carry_in = 1'b0; overflow_in = 1'b0; negative_in = 1'b0; zero_in = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        rd_addr1 = '0; rd_addr2 = '0; cond = 4'd0;
        idle_inputs();
        tick();
        cmp_en = 1'b1;
        tick();
        reset_n = 1'b1;

        // Reset state: every address reads zero on both ports
        for (int i = 0; i < 8; i++) begin
            rd_addr1 = ADDR_BITS'(i);
            rd_addr2 = ADDR_BITS'(7 - i);
            #1;
            check("reset_rd1", 32'(rd_data1), 32'h0);
            check("reset_rd2", 32'(rd_data2), 32'h0);
            tick();
        end
        check("reset_flags", 32'(flags), 32'h0);
        cond = 4'd1; #1;
        check("reset_ne", 32'(branch_taken), 32'h1);
        cond = 4'd0; #1;
        check("reset_eq", 32'(branch_taken), 32'h0);
        tick();

        // Write r3 with same-cycle bypass, then read back from the array
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234; rd_addr1 = 3'd3;
        #1;
        check("bypass_r3", 32'(rd_data1), 32'h1234);
        tick();
        wr_en = 1'b0; wr_data = 16'h0000;
        #1;
        check("stored_r3", 32'(rd_data1), 32'h1234);

        // SUB 5-5: C=1 V=0 N=0 Z=1
        set_flags = 1'b1; alu_op = 3'd1;
        carry_in = 1'b1; overflow_in = 1'b0; negative_in = 1'b0; zero_in = 1'b1;
        tick();
        idle_inputs();
        check("sub_flags", 32'(flags), 32'h9);
        cond = 4'd0;  #1; check("sub_eq", 32'(branch_taken), 32'h1);
        cond = 4'd8;  #1; check("sub_hi", 32'(branch_taken), 32'h0);
        cond = 4'd9;  #1; check("sub_ls", 32'(branch_taken), 32'h1);
        cond = 4'd10; #1; check("sub_ge", 32'(branch_taken), 32'h1);
        tick();

        // Flags 1100, then AND producing 0x8000: C,V held, N from result
        set_flags = 1'b1; alu_op = 3'd0;
        carry_in = 1'b1; overflow_in = 1'b1; negative_in = 1'b0; zero_in = 1'b0;
        tick();
        check("pre_and_flags", 32'(flags), 32'hC);
        alu_op = 3'b010; wr_data = 16'h8000;
        carry_in = 1'b0; overflow_in = 1'b0; negative_in = 1'b0; zero_in = 1'b0;
        tick();
        idle_inputs();
        check("and_flags", 32'(flags), 32'hE);
        cond = 4'd11; #1; check("and_lt", 32'(branch_taken), 32'h0);
        cond = 4'd10; #1; check("and_ge", 32'(branch_taken), 32'h1);
        cond = 4'd4;  #1; check("and_mi", 32'(branch_taken), 32'h1);

        // set_flags=0 with noisy flag inputs: flags hold
        for (int i = 0; i < 10; i++) begin
            alu_op = 3'($urandom_range(0, 7));
            {carry_in, overflow_in, negative_in, zero_in} = 4'($urandom);
            wr_data = 16'($urandom);
            tick();
            check("flags_hold", 32'(flags), 32'hE);
        end
        // Flag-only update with no register write
        set_flags = 1'b1; wr_en = 1'b0; alu_op = 3'd0; wr_addr = 3'd3; wr_data = 16'hFFFF;
        {carry_in, overflow_in, negative_in, zero_in} = 4'b0101;
        tick();
        idle_inputs();
        rd_addr1 = 3'd3; #1;
        check("flag_only_flags", 32'(flags), 32'h5);
        check("flag_only_r3", 32'(rd_data1), 32'h1234);

        // r5=0xBEEF, flags=1111, then a reset edge with a pending write
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
        set_flags = 1'b1; alu_op = 3'd0;
        {carry_in, overflow_in, negative_in, zero_in} = 4'b1111;
        tick();
        check("pre_rst_flags", 32'(flags), 32'hF);
        reset_n = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h0001; set_flags = 1'b1;
        rd_addr1 = 3'd5; rd_addr2 = 3'd5;
        #1;
        check("rst_no_bypass", 32'(rd_data1), 32'hBEEF);
        tick();
        reset_n = 1'b1;
        idle_inputs();
        #1;
        check("post_rst_r5", 32'(rd_data1), 32'h0);
        check("post_rst_flags", 32'(flags), 32'h0);
        tick();

        // Randomized traffic checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            reset_n   = ($urandom_range(0, 59) != 0);
            wr_en     = 1'($urandom);
            wr_addr   = ADDR_BITS'($urandom);
            wr_data   = 16'($urandom);
            alu_op    = 3'($urandom);
            set_flags = 1'($urandom);
            {carry_in, overflow_in, negative_in, zero_in} = 4'($urandom);
            cond      = 4'($urandom);
            rd_addr1  = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_BITS'($urandom);
            rd_addr2  = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_BITS'($urandom);
            tick();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
